// File: rtl/tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen -- square-wave note player.
//
// Takes one 8-bit note command per handshake and plays it on audio_out for a
// fixed duration (N_NOTE cycles), followed by a silent gap (N_GAP cycles).
//
// Handshake: a command is accepted on a rising clk edge where note_valid=1 and
// ready=1. ready is registered and equals ~busy; commands presented while
// ready=0 are dropped, never queued. No backpressure is applied to the source.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   note_valid note command strobe
//   note_code  [7]=rest, [6]=don't care, [5:4]=octave, [3:0]=semitone (C..B)
//   ready      command can be accepted (IDLE)
//   audio_out  square-wave output
//   busy       high in PLAY or GAP
//   done       one-cycle pulse when the gap ends (or the note, if no gap)
//   err        one-cycle pulse after accepting a semitone >= 12 (non-rest)
// -----------------------------------------------------------------------------
module tone_gen #(
  parameter int unsigned C_CLK_FRQ = 100_000_000,
  parameter int unsigned C_NOTE_MS = 500,
  parameter int unsigned C_GAP_MS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       note_valid,
  input  logic [7:0] note_code,
  output logic       ready,
  output logic       audio_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned N_NOTE = (C_CLK_FRQ / 1000) * C_NOTE_MS;
  localparam int unsigned N_GAP  = (C_CLK_FRQ / 1000) * C_GAP_MS;
  localparam int unsigned N_MAX  = (N_NOTE > N_GAP) ? N_NOTE : N_GAP;
  localparam int          DUR_W  = $clog2(N_MAX + 1);
  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(N_NOTE - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(N_GAP - 1);

  // Half-period in cycles for octave 0, rounded: round(clk / (2*f)).
  // fc is the frequency in centihertz so the math stays integral.
  function automatic logic [17:0] half_of(input longint unsigned fc);
    longint unsigned num;
    num = 64'(C_CLK_FRQ) * 100 + fc;
    return 18'(num / (2 * fc));
  endfunction

  // Entries 12..15 are unreachable for sounding notes; zero keeps the lookup
  // in range for rests carrying arbitrary semitone fields.
  localparam logic [17:0] HALF_TBL [16] = '{
    half_of(26163), half_of(27718), half_of(29366), half_of(31113),
    half_of(32963), half_of(34923), half_of(36999), half_of(39200),
    half_of(41530), half_of(44000), half_of(46616), half_of(49388),
    18'd0, 18'd0, 18'd0, 18'd0
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [17:0]      half_cnt_q, half_cnt_d;
  logic [17:0]      half_lim_q, half_lim_d;
  logic             rest_q, rest_d;
  logic             audio_q, audio_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic       accept;
  logic       is_rest;
  logic [3:0] semi;
  logic [1:0] oct;
  logic       unused_bit6;

  assign accept      = note_valid & ready_q;
  assign is_rest     = note_code[7];
  assign semi        = note_code[3:0];
  assign oct         = note_code[5:4];
  assign unused_bit6 = note_code[6];

  always_comb begin
    state_d    = state_q;
    dur_d      = dur_q;
    half_cnt_d = half_cnt_q;
    half_lim_d = half_lim_q;
    rest_d     = rest_q;
    audio_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        dur_d      = '0;
        half_cnt_d = '0;
        if (accept) begin
          if (!is_rest && semi >= 4'd12) begin
            err_d = 1'b1;
          end else begin
            state_d    = S_PLAY;
            rest_d     = is_rest;
            half_lim_d = is_rest ? 18'd0 : (HALF_TBL[semi] >> oct);
          end
        end
      end

      S_PLAY: begin
        if (dur_q == NOTE_LAST) begin
          // Leaving PLAY: any toggle due on this edge is dropped.
          dur_d      = '0;
          half_cnt_d = '0;
          if (N_GAP == 0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          dur_d   = dur_q + 1'b1;
          audio_d = audio_q;
          if (half_cnt_q == half_lim_q - 18'd1) begin
            half_cnt_d = '0;
            audio_d    = rest_q ? 1'b0 : ~audio_q;
          end else begin
            half_cnt_d = half_cnt_q + 18'd1;
          end
        end
      end

      S_GAP: begin
        if (dur_q == GAP_LAST) begin
          state_d = S_IDLE;
          dur_d   = '0;
          done_d  = 1'b1;
        end else begin
          dur_d = dur_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        dur_d   = '0;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = ~busy_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dur_q      <= '0;
      half_cnt_q <= '0;
      half_lim_q <= '0;
      rest_q     <= 1'b0;
      audio_q    <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dur_q      <= dur_d;
      half_cnt_q <= half_cnt_d;
      half_lim_q <= half_lim_d;
      rest_q     <= rest_d;
      audio_q    <= audio_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ready     = ready_q;
  assign audio_out = audio_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
